// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing bundle for the hazard/stall controller: hazard inputs,
// memory handshake and the enable/bubble/flush/freeze outputs.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_Rd_i;
  logic [4:0]       IFID_Rs1_i;
  logic [4:0]       IFID_Rs2_i;
  logic             ID_UsesRs2_i;
  logic             Branch_taken_i;
  logic             EXMEM_MemRead_i;
  logic             EXMEM_MemWrite_i;
  logic             mem_ack_i;
  logic             mem_req_o;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             NoOp_o;
  logic             Flush_o;
  logic             Freeze_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i,
           ID_UsesRs2_i, Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i,
           mem_ack_i,
    input  mem_req_o, PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Freeze_o,
           err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i,
           ID_UsesRs2_i, Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i,
           mem_ack_i,
    output mem_req_o, PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Freeze_o,
           err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Sequencing controller for the 5-stage core: load-use stalls, branch flushes,
// multi-cycle data-memory freeze, memory-wait timeout and event counters.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic clk_i,
  input logic rst_i,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t           state;
  logic [15:0]      waitCnt;
  logic             errQ;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  logic memop;
  logic hazard;

  assign memop  = bus.EXMEM_MemRead_i | bus.EXMEM_MemWrite_i;
  assign hazard = bus.IDEX_MemRead_i && (bus.IDEX_Rd_i != 5'd0) &&
                  ((bus.IDEX_Rd_i == bus.IFID_Rs1_i) ||
                   (bus.ID_UsesRs2_i && (bus.IDEX_Rd_i == bus.IFID_Rs2_i)));

  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.PCWrite_o   = 1'b0;
    bus.IFIDWrite_o = 1'b0;
    bus.NoOp_o      = 1'b0;
    bus.Flush_o     = 1'b0;
    bus.Freeze_o    = 1'b0;
    case (state)
      IDLE: bus.NoOp_o = 1'b1;
      RUN, MEM_WAIT: begin
        bus.mem_req_o = (state == MEM_WAIT) ? 1'b1 : memop;
        if ((state == MEM_WAIT && !bus.mem_ack_i) || (state == RUN && memop && !bus.mem_ack_i)) begin
          bus.Freeze_o = 1'b1;
        end else if (hazard) begin
          // Hazard wins over a taken branch; the branch resolves again next cycle.
          bus.NoOp_o = 1'b1;
        end else begin
          bus.PCWrite_o   = 1'b1;
          bus.IFIDWrite_o = 1'b1;
          bus.Flush_o     = bus.Branch_taken_i;
        end
      end
      default: bus.NoOp_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      waitCnt  <= '0;
      errQ     <= 1'b0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) state <= RUN;
        RUN: begin
          if (memop && !bus.mem_ack_i) begin
            state   <= MEM_WAIT;
            waitCnt <= 16'd1;
            if (TIMEOUT_W == 16'd1) errQ <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack_i) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt != TIMEOUT_W) begin
            waitCnt <= waitCnt + 16'd1;
            if (waitCnt == TIMEOUT_W - 16'd1) errQ <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && !bus.PCWrite_o && stallCnt != '1)
        stallCnt <= stallCnt + CNT_W'(1);
      if (bus.Flush_o && flushCnt != '1)
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign bus.err_o       = errQ;
  assign bus.stall_cnt_o = stallCnt;
  assign bus.flush_cnt_o = flushCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (narrow counters and short timeout so
// saturation and err_o are reachable in a short run).
module tb_hazard_stall_ctrl;

  localparam int unsigned CW = 3;

  // Output bundle order: {mem_req, PCWrite, IFIDWrite, NoOp, Flush, Freeze}
  localparam logic [7:0] O_IDLE = 8'b00_000100;
  localparam logic [7:0] O_RUN  = 8'b00_011000;
  localparam logic [7:0] O_BUB  = 8'b00_000100;
  localparam logic [7:0] O_FL   = 8'b00_011010;
  localparam logic [7:0] O_FRZ  = 8'b00_100001;
  localparam logic [7:0] O_ACK  = 8'b00_111000;
  localparam logic [7:0] O_ACKB = 8'b00_100100;

  logic clk;
  logic rstN;
  int   nVec;
  int   nFail;

  hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_stall_ctrl #(.CNT_W(CW), .TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rstN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {2'b00, bus.mem_req_o, bus.PCWrite_o, bus.IFIDWrite_o,
            bus.NoOp_o, bus.Flush_o, bus.Freeze_o};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    bus.start_i          = 1'b0;
    bus.IDEX_MemRead_i   = 1'b0;
    bus.IDEX_Rd_i        = 5'd0;
    bus.IFID_Rs1_i       = 5'd0;
    bus.IFID_Rs2_i       = 5'd0;
    bus.ID_UsesRs2_i     = 1'b0;
    bus.Branch_taken_i   = 1'b0;
    bus.EXMEM_MemRead_i  = 1'b0;
    bus.EXMEM_MemWrite_i = 1'b0;
    bus.mem_ack_i        = 1'b0;
  endtask

  initial begin
    nVec  = 0;
    nFail = 0;
    rstN  = 1'b0;
    clearIn();
    repeat (3) tick();
    chk("reset_outs", outs(), O_IDLE);
    chk("reset_err", {7'b0, bus.err_o}, 8'd0);
    chk("reset_stall", 8'(bus.stall_cnt_o), 8'd0);
    chk("reset_flush", 8'(bus.flush_cnt_o), 8'd0);

    rstN = 1'b1;
    tick();
    chk("idle_hold", outs(), O_IDLE);
    chk("idle_nostall", 8'(bus.stall_cnt_o), 8'd0);
    bus.start_i = 1'b1;
    #1 chk("start_cycle", outs(), O_IDLE);
    tick();
    bus.start_i = 1'b0;
    #1 chk("run_outs", outs(), O_RUN);

    // load-use on rs1
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_Rd_i = 5'd5; bus.IFID_Rs1_i = 5'd5;
    #1 chk("loaduse_rs1", outs(), O_BUB);
    tick();
    clearIn();
    #1 chk("loaduse_done", outs(), O_RUN);
    chk("stall_cnt_1", 8'(bus.stall_cnt_o), 8'd1);

    // Rd = x0 never stalls
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_Rd_i = 5'd0;
    #1 chk("rd_x0", outs(), O_RUN);
    tick();
    chk("stall_cnt_x0", 8'(bus.stall_cnt_o), 8'd1);

    // rs2 match only counts when the instruction reads rs2
    bus.IDEX_Rd_i = 5'd7; bus.IFID_Rs1_i = 5'd3; bus.IFID_Rs2_i = 5'd7;
    #1 chk("rs2_unused", outs(), O_RUN);
    bus.ID_UsesRs2_i = 1'b1;
    #1 chk("rs2_used", outs(), O_BUB);
    tick();
    clearIn();
    chk("stall_cnt_2", 8'(bus.stall_cnt_o), 8'd2);

    // taken branch flush, then branch masked by hazard
    bus.Branch_taken_i = 1'b1;
    #1 chk("branch_flush", outs(), O_FL);
    tick();
    chk("flush_cnt_1", 8'(bus.flush_cnt_o), 8'd1);
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_Rd_i = 5'd5; bus.IFID_Rs1_i = 5'd5;
    #1 chk("branch_hazard", outs(), O_BUB);
    tick();
    clearIn();
    chk("flush_cnt_hz", 8'(bus.flush_cnt_o), 8'd1);
    chk("stall_cnt_3", 8'(bus.stall_cnt_o), 8'd3);

    // store with ack on the 4th cycle
    bus.EXMEM_MemWrite_i = 1'b1;
    #1 chk("store_c1", outs(), O_FRZ);
    tick();
    chk("store_c2", outs(), O_FRZ);
    tick();
    chk("store_c3", outs(), O_FRZ);
    tick();
    bus.mem_ack_i = 1'b1;
    #1 chk("store_ack", outs(), O_ACK);
    chk("stall_cnt_6", 8'(bus.stall_cnt_o), 8'd6);
    tick();
    clearIn();
    #1 chk("store_back_run", outs(), O_RUN);
    chk("store_noerr", {7'b0, bus.err_o}, 8'd0);

    // zero-wait access: no freeze, stays in RUN
    bus.EXMEM_MemRead_i = 1'b1; bus.mem_ack_i = 1'b1;
    #1 chk("zero_wait", outs(), O_ACK);
    tick();
    clearIn();
    #1 chk("zero_wait_run", outs(), O_RUN);
    chk("stall_cnt_zw", 8'(bus.stall_cnt_o), 8'd6);

    // timeout: err after four frozen cycles, stall counter saturates
    bus.EXMEM_MemRead_i = 1'b1;
    repeat (3) tick();
    chk("err_before_to", {7'b0, bus.err_o}, 8'd0);
    tick();
    chk("err_at_to", {7'b0, bus.err_o}, 8'd1);
    repeat (6) tick();
    chk("to_still_frz", outs(), O_FRZ);
    chk("stall_sat", 8'(bus.stall_cnt_o), 8'd7);
    bus.mem_ack_i = 1'b1;
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_Rd_i = 5'd5; bus.IFID_Rs1_i = 5'd5;
    #1 chk("ack_hazard", outs(), O_ACKB);
    tick();
    clearIn();
    #1 chk("after_to_run", outs(), O_RUN);
    chk("err_sticky", {7'b0, bus.err_o}, 8'd1);
    chk("stall_sat2", 8'(bus.stall_cnt_o), 8'd7);

    // flush counter saturation
    bus.Branch_taken_i = 1'b1;
    repeat (6) tick();
    chk("flush_cnt_7", 8'(bus.flush_cnt_o), 8'd7);
    tick();
    chk("flush_sat", 8'(bus.flush_cnt_o), 8'd7);
    clearIn();

    // async reset in MEM_WAIT
    bus.EXMEM_MemWrite_i = 1'b1;
    tick();
    tick();
    chk("wait_before_rst", outs(), O_FRZ);
    #2 rstN = 1'b0;
    #1 chk("async_rst_outs", outs(), O_IDLE);
    chk("async_rst_err", {7'b0, bus.err_o}, 8'd0);
    chk("async_rst_stall", 8'(bus.stall_cnt_o), 8'd0);
    chk("async_rst_flush", 8'(bus.flush_cnt_o), 8'd0);
    clearIn();
    tick();
    rstN = 1'b1;
    tick();
    chk("post_rst_idle", outs(), O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Sequencing controller for the 5-stage pipelined RISC-V core. It produces the PC write-enable, the IF/ID write-enable, the NoOp request into the main decoder, and the IF/ID flush. It covers load-use hazards, taken-branch flushes and multi-cycle data-memory accesses. It owns a small FSM for core start and memory wait, a memory-wait timeout counter, and saturating performance counters for stall and flush events.

Parameters:
CNT_W, 32, width of stall_cnt_o and flush_cnt_o
TIMEOUT, 64, max MEM_WAIT cycles before err_o sets (range 1..2^16-1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle pulse; releases core from IDLE
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_Rd_i  in  5  destination register of EX instruction
IFID_Rs1_i  in  5  rs1 of ID instruction
IFID_Rs2_i  in  5  rs2 of ID instruction
ID_UsesRs2_i  in  1  ID instruction reads rs2 (R-type, sw, beq)
Branch_taken_i  in  1  ID-stage beq compare resolved taken
EXMEM_MemRead_i  in  1  MEM-stage load
EXMEM_MemWrite_i  in  1  MEM-stage store
mem_ack_i  in  1  data memory completes access this cycle
mem_req_o  out  1  data memory request
PCWrite_o  out  1  PC register enable
IFIDWrite_o  out  1  IF/ID register enable
NoOp_o  out  1  forces the decoder to emit all-zero controls (bubble)
Flush_o  out  1  clears the IF/ID instruction to a nop
Freeze_o  out  1  holds every pipeline register (ID/EX, EX/MEM, MEM/WB too)
err_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0 while not IDLE
flush_cnt_o  out  CNT_W  number of Flush_o cycles

Behaviour:
- States: IDLE, RUN, MEM_WAIT. Reset (rst_i=0, async) -> IDLE, wait counter 0, err_o 0, both counters 0.
- IDLE: PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, Flush_o=0, Freeze_o=0, mem_req_o=0. start_i=1 -> RUN next edge. start_i is ignored in RUN and MEM_WAIT.
- Outputs are combinational (Mealy) from the state and the current inputs. State, wait counter, err_o and the counters are registered.
- memop = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- hazard = IDEX_MemRead_i & (IDEX_Rd_i!=0) & ((IDEX_Rd_i==IFID_Rs1_i) | (ID_UsesRs2_i & IDEX_Rd_i==IFID_Rs2_i)).
- RUN, memop=1 & mem_ack_i=0:
  - Freeze_o=1, mem_req_o=1, PCWrite_o=0, IFIDWrite_o=0, NoOp_o=0, Flush_o=0.
  - Next state MEM_WAIT; wait counter loads 1.
- RUN, otherwise:
  - mem_req_o=memop; a zero-wait ack in the same cycle causes no freeze.
  - hazard=1: PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, Flush_o=0. Hazard has priority over branch; the branch re-evaluates next cycle.
  - hazard=0: PCWrite_o=1, IFIDWrite_o=1, NoOp_o=0, Flush_o=Branch_taken_i.
- MEM_WAIT: mem_req_o=1; request inputs must remain stable because the pipeline is frozen.
  - mem_ack_i=0: Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, NoOp_o=0, Flush_o=0; wait counter +1, saturating at TIMEOUT.
  - mem_ack_i=1: Freeze_o=0, outputs as RUN with hazard/branch evaluated that cycle; next state RUN; wait counter -> 0.
- err_o sets on the edge where the wait counter reaches TIMEOUT while still in MEM_WAIT. It stays set until reset. The FSM keeps waiting; there is no abort.
- stall_cnt_o +1 on each edge where state!=IDLE and PCWrite_o=0. flush_cnt_o +1 on each edge with Flush_o=1. Both saturate at all-ones and never wrap.
- Reset asserted mid-MEM_WAIT -> IDLE immediately and mem_req_o drops asynchronously. The outstanding access is abandoned; the memory must tolerate this.
- Invariants: Freeze_o=1 implies NoOp_o=0 and Flush_o=0. Flush_o=1 implies PCWrite_o=1.

Test Plan:
- Reset low 3 cycles, then start_i pulse -> all IDLE outputs as specified, counters 0; RUN on the edge after start_i, PCWrite_o=1.
- lw x5 in EX, ID rs1=5 -> exactly one cycle with PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1; stall_cnt_o=1. Repeat with Rd=x0 -> no stall.
- Branch_taken_i=1, no hazard -> Flush_o=1 for one cycle, flush_cnt_o=1. Same cycle with hazard=1 -> Flush_o=0, NoOp_o=1.
- Store in MEM, mem_ack_i after 3 cycles -> Freeze_o=1 for 3 cycles and 0 on the ack cycle; mem_req_o high for 4 cycles; stall_cnt_o +3.
- TIMEOUT=4, ack withheld 10 cycles -> err_o rises after 4 MEM_WAIT cycles, stays 1 after the ack, clears only on reset.
- rst_i low during MEM_WAIT -> mem_req_o=0 and Freeze_o=0 without a clock edge; state IDLE.
